// File: rtl/blink_code_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_code_pkg
// Description : Shared state encodings, default timing constants and a small
//               helper for the blink-code LED controller.
// Revision    : 1.0  initial release
// ============================================================================
package blink_code_pkg;

    // FSM state encodings
    localparam logic [1:0] BC_IDLE = 2'd0;
    localparam logic [1:0] BC_ON   = 2'd1;
    localparam logic [1:0] BC_OFF  = 2'd2;
    localparam logic [1:0] BC_GAP  = 2'd3;

    // Default timing constants
    localparam int C_DEF_FREQUENCY = 25_000_000;
    localparam int C_DEF_TICK_HZ   = 10;
    localparam int C_DEF_ON_TICKS  = 2;
    localparam int C_DEF_OFF_TICKS = 3;
    localparam int C_DEF_GAP_TICKS = 10;
    localparam int C_DEF_CODE_W    = 4;

    // Largest of three phase lengths, used to size the phase counter
    function automatic int bc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blink_tick.sv
`default_nettype none
// ============================================================================
// Module      : blink_tick
// Description : Reloadable prescaler. Counts 0..DIV and wraps, emitting a
//               one-cycle tick when the count equals DIV. clr_i holds the
//               counter at zero.
// Revision    : 1.0  initial release
// ============================================================================
module blink_tick #(
    parameter int DIV = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int C_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

    logic [C_W-1:0] r_cnt;
    logic           w_at_div;

    assign w_at_div = (r_cnt == C_W'(DIV));
    assign tick_o   = ~clr_i & w_at_div;

    // Free-running prescale counter, wraps DIV -> 0
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (w_at_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/blink_code.sv
`default_nettype none
// ============================================================================
// Module      : blink_code
// Description : Blink-code LED controller. Displays code N as N equal pulses
//               followed by a long gap, repeating. New codes arrive over a
//               valid/ready handshake; one code may wait in a pending slot
//               and is picked up at the next frame end.
//               Optional macro BLINK_CODE_DONE_EN adds the done_o frame-end
//               pulse output.
// Revision    : 1.0  initial release
// ============================================================================
module blink_code
    import blink_code_pkg::*;
#(
    parameter int FREQUENCY = C_DEF_FREQUENCY,
    parameter int TICK_HZ   = C_DEF_TICK_HZ,
    parameter int ON_TICKS  = C_DEF_ON_TICKS,
    parameter int OFF_TICKS = C_DEF_OFF_TICKS,
    parameter int GAP_TICKS = C_DEF_GAP_TICKS,
    parameter int CODE_W    = C_DEF_CODE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              load_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              led_o
`ifdef BLINK_CODE_DONE_EN
   ,output logic              done_o
`endif
);

    localparam int C_DIV    = FREQUENCY / TICK_HZ - 1;
    localparam int C_PH_MAX = bc_max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int C_PH_W   = $clog2(C_PH_MAX + 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CODE_W-1:0] r_cur_code;
    logic [CODE_W-1:0] r_remaining;
    logic [C_PH_W-1:0] r_phase;
    logic [CODE_W-1:0] r_pend_code;
    logic              r_pend_valid;
    logic              r_led;

    logic w_tick;
    logic w_xfer;
    logic w_on_last;
    logic w_off_last;
    logic w_gap_last;
    logic w_frame_end;

    // Prescaler is held cleared whenever idle, so the first ON phase after a
    // load starts from a fresh count.
    blink_tick #(
        .DIV (C_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (r_state == BC_IDLE),
        .tick_o (w_tick)
    );

    assign ready_o     = ~r_pend_valid;
    assign busy_o      = (r_state != BC_IDLE);
    assign led_o       = r_led;
    assign w_xfer      = load_i & ready_o;
    assign w_on_last   = w_tick & (r_phase == C_PH_W'(ON_TICKS - 1));
    assign w_off_last  = w_tick & (r_phase == C_PH_W'(OFF_TICKS - 1));
    assign w_gap_last  = w_tick & (r_phase == C_PH_W'(GAP_TICKS - 1));
    assign w_frame_end = (r_state == BC_GAP) & w_gap_last;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BC_IDLE: if (w_xfer && (code_i != '0)) w_state_nxt = BC_ON;
            BC_ON:   if (w_on_last)                w_state_nxt = BC_OFF;
            BC_OFF:  if (w_off_last)
                         w_state_nxt = (r_remaining > CODE_W'(1)) ? BC_ON : BC_GAP;
            BC_GAP:  if (w_gap_last)
                         w_state_nxt = (r_pend_valid && (r_pend_code == '0)) ? BC_IDLE : BC_ON;
            default: w_state_nxt = BC_IDLE;
        endcase
    end

    // FSM, code counters, phase counter, pending slot and LED register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= BC_IDLE;
            r_cur_code   <= '0;
            r_remaining  <= '0;
            r_phase      <= '0;
            r_pend_code  <= '0;
            r_pend_valid <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Register the LED from the next state so it tracks ON exactly
            r_led   <= (w_state_nxt == BC_ON);

            if (w_state_nxt != r_state) begin
                r_phase <= '0;
            end else if (w_tick && (r_state != BC_IDLE)) begin
                r_phase <= r_phase + C_PH_W'(1);
            end

            case (r_state)
                BC_IDLE: begin
                    if (w_xfer && (code_i != '0)) begin
                        r_cur_code  <= code_i;
                        r_remaining <= code_i;
                    end
                end
                BC_OFF: begin
                    if (w_off_last && (r_remaining > CODE_W'(1))) begin
                        r_remaining <= r_remaining - CODE_W'(1);
                    end
                end
                BC_GAP: begin
                    if (w_frame_end) begin
                        if (r_pend_valid && (r_pend_code != '0)) begin
                            r_cur_code  <= r_pend_code;
                            r_remaining <= r_pend_code;
                        end else if (!r_pend_valid) begin
                            r_remaining <= r_cur_code;
                        end
                        r_pend_valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A transfer can only happen with the slot empty, so it never
            // collides with a consumption; it takes priority over the clear.
            if (w_xfer && (r_state != BC_IDLE)) begin
                r_pend_code  <= code_i;
                r_pend_valid <= 1'b1;
            end
        end
    end

`ifdef BLINK_CODE_DONE_EN
    logic r_done;

    // One-cycle pulse in the first cycle after each frame end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_frame_end;
        end
    end

    assign done_o = r_done;
`endif

endmodule
`default_nettype wire
